// File: rtl/matrix_load_sequencer.sv
// Byte-stream front end for the matrix coprocessor operand buffer: parses a size_x/size_y
// header, streams the payload into operand RAM and holds the buffer until the engine releases it.
module matrix_load_sequencer #(
  parameter int MIN_DIM = 2,
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_consumed,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [7:0]        o_size_x,
  output logic [7:0]        o_size_y,
  output logic [7:0]        o_data_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] IDLE_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GET_Y,
    S_LOAD,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [7:0]        size_x_q, size_y_q, data_len_q, cnt_q;
  logic [TO_W-1:0]   idle_q;
  logic              wr_en_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic       accept;
  logic       x_legal, y_legal, last_byte, timeout_hit;
  logic [7:0] sq_x, len_d;

  assign o_ready = !reset && (state_q != S_HOLD);
  assign o_busy  = (state_q != S_IDLE);
  assign accept  = i_valid && o_ready;

  assign x_legal = (i_byte >= 8'(MIN_DIM)) && (i_byte <= 8'(MAX_DIM));
  assign y_legal = (i_byte == 8'd0) || (i_byte == size_x_q);

  // size_x is already range-checked here, so 2*x*x always fits in 8 bits.
  assign sq_x  = size_x_q * size_x_q;
  assign len_d = (i_byte == 8'd0) ? (sq_x << 1) : (sq_x + 8'd1);

  assign last_byte   = (cnt_q == data_len_q - 8'd1);
  assign timeout_hit = (TIMEOUT != 0) && !accept && (idle_q == IDLE_LAST);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      size_x_q   <= '0;
      size_y_q   <= '0;
      data_len_q <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each assertion below is exactly one cycle wide.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;

      if (accept || state_q == S_IDLE || state_q == S_HOLD) begin
        idle_q <= '0;
      end else if (TIMEOUT != 0) begin
        idle_q <= idle_q + TO_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            size_x_q <= i_byte;
            if (x_legal) state_q <= S_GET_Y;
            else         err_q   <= 1'b1;
          end
        end

        S_GET_Y: begin
          if (accept) begin
            size_y_q <= i_byte;
            if (y_legal) begin
              data_len_q <= len_d;
              cnt_q      <= '0;
              state_q    <= S_LOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_W'(cnt_q);
            wr_data_q <= i_byte;
            cnt_q     <= cnt_q + 8'd1;
            if (last_byte) begin
              done_q  <= 1'b1;
              state_q <= S_HOLD;
            end
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_HOLD: begin
          // Release wins over a same-cycle byte: o_ready is low, so that byte is simply not taken.
          if (i_consumed)   state_q <= S_IDLE;
          else if (i_valid) err_q   <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_size_x   = size_x_q;
  assign o_size_y   = size_y_q;
  assign o_data_len = data_len_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Self-checking bench for matrix_load_sequencer: directed scenarios plus randomized frames
// checked against a stream-level reference model of the header/payload rules.
module tb_matrix_load_sequencer;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;

  typedef logic [7:0] bytes_t[$];

  logic              i_clk      = 1'b0;
  logic              reset      = 1'b1;
  logic [7:0]        i_byte     = 8'd0;
  logic              i_valid    = 1'b0;
  logic              i_consumed = 1'b0;
  logic              o_ready, o_wr_en, o_busy, o_done, o_err;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data, o_size_x, o_size_y, o_data_len;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int overlap = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_stamp[$];
  int done_stamp[$];
  int err_stamp[$];

  matrix_load_sequencer #(
    .MIN_DIM(2), .MAX_DIM(5), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .reset(reset), .i_byte(i_byte), .i_valid(i_valid), .o_ready(o_ready),
    .i_consumed(i_consumed), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_size_x(o_size_x), .o_size_y(o_size_y), .o_data_len(o_data_len), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle; stamps name the rising edge that produced the event.
  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) begin
      wr_addr.push_back(int'(o_wr_addr));
      wr_data.push_back(int'(o_wr_data));
      wr_stamp.push_back(cyc);
    end
    if (o_done === 1'b1) done_stamp.push_back(cyc);
    if (o_err === 1'b1) err_stamp.push_back(cyc);
    if (o_err === 1'b1 && o_done === 1'b1) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_len(input int x, input int y);
    return (y == 0) ? 2 * x * x : x * x + 1;
  endfunction

  function automatic bit ref_x_legal(input int x);
    return (x >= 2) && (x <= 5);
  endfunction

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_stamp.delete();
    done_stamp.delete(); err_stamp.delete();
  endtask

  // Presents one byte for one cycle; stamp is the edge at which it would be taken.
  task automatic put(input logic [7:0] b, input int gap, output int stamp, output bit acc);
    repeat (gap) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_consumed = 1'b0;
    end
    @(negedge i_clk);
    i_valid = 1'b1; i_byte = b; i_consumed = 1'b0;
    acc   = o_ready;
    stamp = cyc + 1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_valid = 1'b0; i_consumed = 1'b0;
    end
  endtask

  task automatic send_stream(input bytes_t s, input int max_gap, output int last_stamp);
    int st;
    bit acc;
    last_stamp = 0;
    foreach (s[i]) begin
      put(s[i], (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)), st, acc);
      last_stamp = st;
    end
    quiet(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge i_clk);
    tests++;
    if (o_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b want 0", o_ready);
    end
    tests++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_size_x, o_size_y, o_data_len, o_busy, o_done, o_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wr_en=%b addr=%0d x=%0d y=%0d len=%0d busy=%b done=%b err=%b, want all 0",
               o_wr_en, o_wr_addr, o_size_x, o_size_y, o_data_len, o_busy, o_done, o_err);
    end
    reset = 1'b0;
    @(negedge i_clk);
    tests++;
    if (o_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b want 1", o_ready);
    end
  endtask

  task automatic test_basic();
    bytes_t s;
    int last, bad;
    s = '{8'd3, 8'd3};
    for (int i = 1; i <= 10; i++) s.push_back(8'(i));
    clear_log();
    send_stream(s, 0, last);
    quiet(3);
    tests++;
    if (o_data_len !== 8'd10 || o_size_x !== 8'd3 || o_size_y !== 8'd3 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_header: len=%0d x=%0d y=%0d busy=%b want 10 3 3 1", o_data_len, o_size_x, o_size_y, o_busy);
    end
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != i + 1) bad++;
    tests++;
    if (wr_addr.size() != 10 || bad != 0) begin
      fails++; $display("FAIL basic_writes: %0d writes %0d wrong, want 10 writes 0 wrong", wr_addr.size(), bad);
    end
    tests++;
    if (done_stamp.size() != 1 || done_stamp[0] != last || wr_stamp[9] != last || err_stamp.size() != 0) begin
      fails++;
      $display("FAIL basic_done: %0d dones at %0d, last write at %0d, %0d errs; want 1 done at %0d with last write, 0 errs",
               done_stamp.size(), done_stamp[0], wr_stamp[9], err_stamp.size(), last);
    end
  endtask

  task automatic test_hold();
    bytes_t s, pl;
    int last, st, bad;
    bit acc;
    s = '{8'd2, 8'd0};
    for (int i = 0; i < 8; i++) begin
      pl.push_back(8'($urandom_range(255, 0)));
      s.push_back(pl[i]);
    end
    clear_log();
    send_stream(s, 0, last);
    quiet(2);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != int'(pl[i])) bad++;
    tests++;
    if (o_data_len !== 8'd8 || wr_addr.size() != 8 || bad != 0 || done_stamp.size() != 1) begin
      fails++;
      $display("FAIL hold_frame: len=%0d writes=%0d wrong=%0d dones=%0d want 8 8 0 1",
               o_data_len, wr_addr.size(), bad, done_stamp.size());
    end
    clear_log();
    put(8'hA5, 0, st, acc);
    quiet(3);
    tests++;
    if (acc !== 1'b0) begin
      fails++; $display("FAIL hold_ready: o_ready=%b in HOLD, want 0", acc);
    end
    tests++;
    if (err_stamp.size() != 1 || err_stamp[0] != st || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL hold_drop: errs=%0d at %0d writes=%0d want 1 err at %0d, 0 writes",
               err_stamp.size(), err_stamp[0], wr_addr.size(), st);
    end
    tests++;
    if (o_busy !== 1'b1 || o_size_x !== 8'd2 || o_size_y !== 8'd0 || o_data_len !== 8'd8) begin
      fails++;
      $display("FAIL hold_stable: busy=%b x=%0d y=%0d len=%0d want 1 2 0 8", o_busy, o_size_x, o_size_y, o_data_len);
    end
    clear_log();
    @(negedge i_clk);
    i_consumed = 1'b1; i_valid = 1'b1; i_byte = 8'd3;
    quiet(3);
    tests++;
    if (o_busy !== 1'b0 || err_stamp.size() != 0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL hold_release: busy=%b errs=%0d writes=%0d want 0 0 0", o_busy, err_stamp.size(), wr_addr.size());
    end
  endtask

  task automatic test_bad_header();
    int st[4];
    bit acc;
    clear_log();
    put(8'd6, 0, st[0], acc);
    put(8'd1, 0, st[1], acc);
    put(8'd5, 0, st[2], acc);
    put(8'd4, 0, st[3], acc);
    quiet(3);
    tests++;
    if (err_stamp.size() != 3 || err_stamp[0] != st[0] || err_stamp[1] != st[1] || err_stamp[2] != st[3]) begin
      fails++;
      $display("FAIL bad_header_errs: %0d errs at %0d,%0d,%0d want 3 at %0d,%0d,%0d",
               err_stamp.size(), err_stamp[0], err_stamp[1], err_stamp[2], st[0], st[1], st[3]);
    end
    tests++;
    if (o_busy !== 1'b0 || wr_addr.size() != 0 || done_stamp.size() != 0 || o_size_x !== 8'd5 || o_size_y !== 8'd4) begin
      fails++;
      $display("FAIL bad_header_state: busy=%b writes=%0d dones=%0d x=%0d y=%0d want 0 0 0 5 4",
               o_busy, wr_addr.size(), done_stamp.size(), o_size_x, o_size_y);
    end
  endtask

  task automatic test_timeout();
    bytes_t s, pl;
    int last, bad, st;
    int stamps[5];
    bit acc;
    s = '{8'd5, 8'd0};
    for (int i = 0; i < 20; i++) begin
      pl.push_back(8'($urandom_range(255, 0)));
      s.push_back(pl[i]);
    end
    clear_log();
    send_stream(s, 0, last);
    quiet(TIMEOUT + 8);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != int'(pl[i])) bad++;
    tests++;
    if (wr_addr.size() != 20 || bad != 0) begin
      fails++; $display("FAIL timeout_writes: %0d writes %0d wrong want 20 0", wr_addr.size(), bad);
    end
    tests++;
    if (err_stamp.size() != 1 || err_stamp[0] != last + TIMEOUT || done_stamp.size() != 0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err: errs=%0d at %0d dones=%0d busy=%b want 1 err at %0d, 0 dones, busy 0",
               err_stamp.size(), err_stamp[0], done_stamp.size(), o_busy, last + TIMEOUT);
    end
    // A gap one cycle short of the limit must not abort the frame.
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom_range(255, 0)));
    clear_log();
    put(8'd2, 0, st, acc);
    put(8'd2, 0, st, acc);
    for (int i = 0; i < 5; i++) put(pl[i], (i == 2) ? TIMEOUT - 1 : 0, stamps[i], acc);
    quiet(3);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != int'(pl[i])) bad++;
    tests++;
    if (wr_addr.size() != 5 || bad != 0 || o_data_len !== 8'd5) begin
      fails++; $display("FAIL timeout_next_writes: %0d writes %0d wrong len=%0d want 5 0 5", wr_addr.size(), bad, o_data_len);
    end
    tests++;
    if (done_stamp.size() != 1 || done_stamp[0] != stamps[4] || err_stamp.size() != 0) begin
      fails++;
      $display("FAIL timeout_next_done: dones=%0d at %0d errs=%0d want 1 at %0d, 0 errs",
               done_stamp.size(), done_stamp[0], err_stamp.size(), stamps[4]);
    end
    @(negedge i_clk); i_consumed = 1'b1;
    quiet(2);
  endtask

  task automatic test_reset_mid();
    bytes_t s;
    int last, bad;
    s = '{8'd3, 8'd0, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    for (int i = 0; i < s.size(); i++) begin
      int st;
      bit acc;
      put(s[i], 0, st, acc);
    end
    @(negedge i_clk);
    reset = 1'b1; i_valid = 1'b1; i_byte = 8'h55;
    @(negedge i_clk);
    tests++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_size_x, o_size_y, o_data_len, o_busy, o_done, o_err, o_ready} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: wr_en=%b x=%0d len=%0d busy=%b ready=%b want all 0",
               o_wr_en, o_size_x, o_data_len, o_busy, o_ready);
    end
    reset = 1'b0; i_valid = 1'b0;
    quiet(2);
    tests++;
    if (wr_addr.size() != 4 || done_stamp.size() != 0 || err_stamp.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_abandon: writes=%0d dones=%0d errs=%0d want 4 0 0",
               wr_addr.size(), done_stamp.size(), err_stamp.size());
    end
    s = '{8'd2, 8'd0};
    for (int i = 0; i < 8; i++) s.push_back(8'(8'hA0 + i));
    clear_log();
    send_stream(s, 0, last);
    quiet(2);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != 8'hA0 + i) bad++;
    tests++;
    if (wr_addr.size() != 8 || bad != 0 || done_stamp.size() != 1 || done_stamp[0] != last) begin
      fails++;
      $display("FAIL reset_mid_next: writes=%0d wrong=%0d dones=%0d want 8 0 1", wr_addr.size(), bad, done_stamp.size());
    end
    @(negedge i_clk); i_consumed = 1'b1;
    quiet(2);
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 14; it++) begin
      bytes_t s, pl;
      int x, y, len, last, bad;
      bit legal;
      if (it == 0) begin
        x = 5; y = 5;
      end else begin
        x = int'($urandom_range(7, 0));
        case ($urandom_range(2, 0))
          0:       y = 0;
          1:       y = x;
          default: y = x + 1;
        endcase
      end
      legal = ref_x_legal(x) && (y == 0 || y == x);
      s.push_back(8'(x));
      if (ref_x_legal(x)) s.push_back(8'(y));
      len = legal ? ref_len(x, y) : 0;
      for (int i = 0; i < len; i++) begin
        pl.push_back(8'($urandom_range(255, 0)));
        s.push_back(pl[i]);
      end
      clear_log();
      send_stream(s, 3, last);
      quiet(2);
      if (legal) begin
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != int'(pl[i])) bad++;
        tests++;
        if (o_size_x !== 8'(x) || o_size_y !== 8'(y) || o_data_len !== 8'(len) || o_busy !== 1'b1) begin
          fails++;
          $display("FAIL rand_header[%0d]: x=%0d y=%0d len=%0d busy=%b want %0d %0d %0d 1",
                   it, o_size_x, o_size_y, o_data_len, o_busy, x, y, len);
        end
        tests++;
        if (wr_addr.size() != len || bad != 0 || done_stamp.size() != 1 || done_stamp[0] != last || err_stamp.size() != 0) begin
          fails++;
          $display("FAIL rand_payload[%0d]: writes=%0d wrong=%0d dones=%0d errs=%0d want %0d 0 1 0",
                   it, wr_addr.size(), bad, done_stamp.size(), err_stamp.size(), len);
        end
        @(negedge i_clk); i_consumed = 1'b1;
      end else begin
        tests++;
        if (err_stamp.size() != 1 || err_stamp[0] != last || wr_addr.size() != 0 || done_stamp.size() != 0 || o_busy !== 1'b0) begin
          fails++;
          $display("FAIL rand_reject[%0d] x=%0d y=%0d: errs=%0d at %0d writes=%0d busy=%b want 1 err at %0d, 0 writes, busy 0",
                   it, x, y, err_stamp.size(), err_stamp[0], wr_addr.size(), o_busy, last);
        end
      end
    end
    quiet(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    @(negedge i_clk); i_consumed = 1'b1;
    quiet(2);
    test_hold();
    test_bad_header();
    test_timeout();
    test_reset_mid();
    test_random_frames();
    tests++;
    if (overlap !== 0) begin
      fails++; $display("FAIL done_err_overlap: %0d cycles with both high, want 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
